write_buffer_drain: RTL
=======================

WRITE_BUFFER_DRAIN -- requirements
Module: write_buffer_drain

Interface
REQ-001 Parameter ADDR_W, default 32, bus address width in bits.
REQ-002 Parameter DATA_W, default 32, bus data width in bits.
REQ-003 Parameter CNT_W, default 4, width of the write-buffer occupancy count.
REQ-004 Parameter MAX_RETRY, default 7, number of bus retries allowed per entry before error.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 clr_n  input  1  reset, asynchronous and active-low.
REQ-007 fifo_data  input  ADDR_W+DATA_W  head entry of the write buffer: {addr, data}, addr in the MSBs.
REQ-008 fifo_cnt  input  CNT_W  write-buffer occupancy.
REQ-009 fifo_pop  output  1  one-cycle pulse that removes the head entry.
REQ-010 drain_en  input  1  permission to start new bus transactions.
REQ-011 flush  input  1  level request from the cache controller to empty the buffer.
REQ-012 flush_done  output  1  buffer empty and block idle while flush is high.
REQ-013 bus_req  output  1  shared-bus request to the arbiter.
REQ-014 bus_gnt  input  1  arbiter grant.
REQ-015 bus_we  output  1  write strobe; high only in XFER.
REQ-016 bus_addr  output  ADDR_W  write address.
REQ-017 bus_data  output  DATA_W  write data.
REQ-018 bus_ack  input  1  slave accepted the write.
REQ-019 bus_retry  input  1  slave rejected the write; reissue it.
REQ-020 err  output  1  sticky error: retry limit exceeded.

Function
REQ-021 FSM states: IDLE, REQ, XFER, DONE, ERR; all outputs registered.
REQ-022 IDLE->REQ when fifo_cnt!=0 and (drain_en or flush); on this edge fifo_data is latched into bus_addr/bus_data and the retry counter is cleared.
REQ-023 bus_addr/bus_data hold their latched value from REQ through DONE, independent of fifo_data.
REQ-024 In REQ: bus_req=1; REQ->XFER on the first cycle bus_gnt=1.
REQ-025 In XFER: bus_req=1, bus_we=1; bus_ack -> DONE; bus_retry (no ack) -> REQ with retry counter +1; neither -> stay.
REQ-026 bus_ack and bus_retry high in the same cycle: ack wins.
REQ-027 A retry that would make the counter exceed MAX_RETRY -> ERR instead of REQ.
REQ-028 In DONE: fifo_pop=1 for exactly one cycle, then DONE->IDLE unconditionally, so IDLE samples the post-pop fifo_cnt.
REQ-029 Exactly one fifo_pop per acked entry; fifo_pop is never asserted when fifo_cnt==0 or in any state but DONE.
REQ-030 Deasserting drain_en mid-transaction does not abort it; it only blocks the next IDLE->REQ.
REQ-031 flush overrides drain_en==0 for starting transactions.
REQ-032 flush_done=1 exactly when flush=1, state=IDLE and fifo_cnt==0, registered (one-cycle lag).
REQ-033 ERR: bus_req=0, bus_we=0, fifo_pop=0, err=1; leaves ERR only through clr_n.
REQ-034 Minimum entry cost: 4 cycles (IDLE, REQ, XFER, DONE) with grant and ack in the first cycle of their states.

Reset
REQ-035 clr_n low asynchronously forces: state IDLE, bus_req=0, bus_we=0, fifo_pop=0, flush_done=0, err=0, bus_addr=0, bus_data=0, retry counter 0.
REQ-036 Reset asserted mid-transaction abandons the transfer without popping; the entry is re-sent after reset.

Structure
REQ-037 State encoding and the {addr,data} field split (ADDR_LSB, ADDR_MSB) belong in the shared cache package.
REQ-038 Retry counter width is derived from MAX_RETRY in the package, not hard-coded.
REQ-039 No sub-module; one FSM with its datapath registers.

Verification
REQ-040 Single entry {0x0000_0100, 0xDEAD_BEEF}, drain_en=1, gnt and ack immediate -> bus_addr=0x100, bus_data=0xDEADBEEF in XFER, one fifo_pop, back in IDLE after 4 cycles.
REQ-041 Three entries queued, gnt delayed 2 cycles for each -> three transactions in order, three pops, no pop when fifo_cnt==0.
REQ-042 bus_retry twice then ack -> REQ re-entered twice, same addr/data reissued, one pop, err=0.
REQ-043 bus_retry MAX_RETRY+1 times (8 with default) -> ERR, err=1, bus_req=0, no pop; clr_n pulse -> IDLE, err=0.
REQ-044 drain_en=0, two entries, flush raised -> both drained, flush_done=1 one cycle after fifo_cnt reaches 0.
REQ-045 clr_n pulsed during XFER -> all outputs zero immediately, no pop, entry re-sent after release.

Source files
------------

// File: rtl/write_buffer_drain_pkg.sv
// Shared cache package: drain FSM state encoding, {addr,data} field split
// and retry-counter sizing helpers.
package write_buffer_drain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_DONE,
    ST_ERR
  } wbd_state_e;

  // Write-buffer entries are packed {addr, data}, so the address sits above the data.
  function automatic int addr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int addr_msb(input int addr_w, input int data_w);
    return addr_w + data_w - 1;
  endfunction

  // Wide enough to hold every value from 0 up to max_retry.
  function automatic int retry_cnt_w(input int max_retry);
    return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
  endfunction

endpackage

// File: rtl/write_buffer_drain.sv
// Drains write-buffer entries onto the shared bus one at a time, reissuing
// on bus_retry and locking up in a sticky error after too many retries.
module write_buffer_drain
  import write_buffer_drain_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 4,
  parameter int MAX_RETRY = 7
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic [ADDR_W+DATA_W-1:0] fifo_data,
  input  logic [CNT_W-1:0]         fifo_cnt,
  output logic                     fifo_pop,
  input  logic                     drain_en,
  input  logic                     flush,
  output logic                     flush_done,
  output logic                     bus_req,
  input  logic                     bus_gnt,
  output logic                     bus_we,
  output logic [ADDR_W-1:0]        bus_addr,
  output logic [DATA_W-1:0]        bus_data,
  input  logic                     bus_ack,
  input  logic                     bus_retry,
  output logic                     err
);

  localparam int ADDR_LSB = addr_lsb(DATA_W);
  localparam int ADDR_MSB = addr_msb(ADDR_W, DATA_W);
  localparam int RTRY_W   = retry_cnt_w(MAX_RETRY);
  localparam logic [RTRY_W-1:0] RTRY_MAX = RTRY_W'(MAX_RETRY);

  wbd_state_e        state, state_nxt;
  logic [RTRY_W-1:0] retry_cnt, retry_nxt;
  logic              start;

  assign start = (fifo_cnt != '0) && (drain_en || flush);

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_REQ;
          retry_nxt = '0;
        end
      end
      ST_REQ: begin
        if (bus_gnt) state_nxt = ST_XFER;
      end
      ST_XFER: begin
        // ack takes priority over a simultaneous retry
        if (bus_ack) begin
          state_nxt = ST_DONE;
        end else if (bus_retry) begin
          if (retry_cnt == RTRY_MAX) begin
            state_nxt = ST_ERR;
          end else begin
            state_nxt = ST_REQ;
            retry_nxt = retry_cnt + RTRY_W'(1);
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      ST_ERR:  state_nxt = ST_ERR;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet line up with the state.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= ST_IDLE;
      retry_cnt  <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      fifo_pop   <= 1'b0;
      err        <= 1'b0;
      flush_done <= 1'b0;
      bus_addr   <= '0;
      bus_data   <= '0;
    end else begin
      state      <= state_nxt;
      retry_cnt  <= retry_nxt;
      bus_req    <= (state_nxt == ST_REQ) || (state_nxt == ST_XFER);
      bus_we     <= (state_nxt == ST_XFER);
      fifo_pop   <= (state_nxt == ST_DONE);
      err        <= (state_nxt == ST_ERR);
      flush_done <= flush && (state == ST_IDLE) && (fifo_cnt == '0);
      if ((state == ST_IDLE) && start) begin
        bus_addr <= fifo_data[ADDR_MSB:ADDR_LSB];
        bus_data <= fifo_data[DATA_W-1:0];
      end
    end
  end

endmodule
